mem_fabric_arb: RTL and testbench

- Parametrised memory interconnect that succeeds the fixed SoC decode/select glue.
- Arbitrates a fetch port and a data (load/store) port onto one shared region bus.
- Decodes NUM_REGIONS address windows, each with its own permissions and programmable wait states. Flags bad accesses and returns a registered response with a ready pulse so the core can stall.
- Sits between the core and the memory/IO instances inside the SoC top.

---
 rtl/mem_fabric_arb_if.sv | 39 +++
 rtl/mem_fabric_arb.sv | 194 +++++++++++++++++++
 tb/tb_mem_fabric_arb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_fabric_arb_if.sv
// Core/memory-side bus bundle for mem_fabric_arb.
// The fabric connects through the slave modport and the core/memory side through master.
interface mem_fabric_arb_if #(
   parameter int unsigned W  = 64,
   parameter int unsigned NR = 4
);
   logic            i_f_req;
   logic [W-1:0]    i_f_addr;
   logic            o_f_rdy;
   logic [31:0]     o_f_instr;
   logic            o_f_bad;
   logic            i_d_req;
   logic            i_d_we;
   logic [W-1:0]    i_d_addr;
   logic [W-1:0]    i_d_wdata;
   logic [1:0]      i_d_size;
   logic            o_d_rdy;
   logic [W-1:0]    o_d_rdata;
   logic            o_d_bad_load;
   logic            o_d_bad_store;
   logic [NR-1:0]   o_r_sel;
   logic [W-1:0]    o_r_addr;
   logic            o_r_we;
   logic [W-1:0]    o_r_wdata;
   logic [1:0]      o_r_size;
   logic [NR*W-1:0] i_r_rdata;

   modport slave (
      input  i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_size, i_r_rdata,
      output o_f_rdy, o_f_instr, o_f_bad, o_d_rdy, o_d_rdata, o_d_bad_load, o_d_bad_store,
             o_r_sel, o_r_addr, o_r_we, o_r_wdata, o_r_size
   );

   modport master (
      output i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_size, i_r_rdata,
      input  o_f_rdy, o_f_instr, o_f_bad, o_d_rdy, o_d_rdata, o_d_bad_load, o_d_bad_store,
             o_r_sel, o_r_addr, o_r_we, o_r_wdata, o_r_size
   );
endinterface

// File: rtl/mem_fabric_arb.sv
// Fetch/data arbiter onto a shared region bus with window decode, permissions,
// per-region wait states and a registered one-cycle response.
module mem_fabric_arb #(
   parameter logic [1:0]                             XLEN        = 2'b10,
   parameter int unsigned                            NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*(1<<(XLEN+4))-1:0]   REGION_BASE = {64'h4000, 64'h2000, 64'h1000, 64'h0},
   parameter logic [NUM_REGIONS*(1<<(XLEN+4))-1:0]   REGION_END  = {64'h40FF, 64'h3FFF, 64'h1FFF, 64'h0FFF},
   parameter logic [NUM_REGIONS*4-1:0]               REGION_WAIT = {4'd3, 4'd0, 4'd1, 4'd0},
   parameter logic [NUM_REGIONS-1:0]                 REGION_RO   = 4'b0011,
   parameter logic [NUM_REGIONS-1:0]                 REGION_X    = 4'b0001
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clk_en,
   mem_fabric_arb_if.slave bus
);
   localparam int unsigned W  = 1 << (XLEN + 4);
   localparam int unsigned IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             own_f_q, own_f_d;
   logic [W-1:0]     off_q, off_d;
   logic [W-1:0]     wdata_q, wdata_d;
   logic [W-1:0]     rdata_q, rdata_d;
   logic             we_q, we_d;
   logic [1:0]       size_q, size_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             bad_q, bad_d;
   logic             fair_q, fair_d;
   logic             f_rdy_q, f_rdy_d;
   logic [31:0]      f_instr_q, f_instr_d;
   logic             f_bad_q, f_bad_d;
   logic             d_rdy_q, d_rdy_d;
   logic [W-1:0]     d_rdata_q, d_rdata_d;
   logic             bad_ld_q, bad_ld_d;
   logic             bad_st_q, bad_st_d;

   logic             take_f;
   logic [W-1:0]     req_addr;
   logic             hit;
   logic [IW-1:0]    hit_idx;
   logic [W-1:0]     hit_base;
   logic             misalign;
   logic             req_bad;
   logic             busy;

   // Arbitration and decode of whichever request would win this cycle.
   always_comb begin
      take_f   = bus.i_f_req && (!bus.i_d_req || fair_q);
      req_addr = take_f ? bus.i_f_addr : bus.i_d_addr;
      hit      = 1'b0;
      hit_idx  = '0;
      hit_base = '0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
         if (!hit && req_addr >= REGION_BASE[i*W +: W] && req_addr <= REGION_END[i*W +: W]) begin
            hit      = 1'b1;
            hit_idx  = IW'(i);
            hit_base = REGION_BASE[i*W +: W];
         end
      end
      unique case (bus.i_d_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = req_addr[0];
         2'd2:    misalign = |req_addr[1:0];
         default: misalign = (|req_addr[2:0]) || (XLEN == 2'b01);
      endcase
      if (!hit)
         req_bad = 1'b1;
      else if (take_f)
         req_bad = !REGION_X[hit_idx] || (req_addr[1:0] != 2'b00);
      else
         req_bad = misalign || (bus.i_d_we && REGION_RO[hit_idx]);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      own_f_d   = own_f_q;
      off_d     = off_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      we_d      = we_q;
      size_d    = size_q;
      idx_d     = idx_q;
      bad_d     = bad_q;
      fair_d    = fair_q;
      f_rdy_d   = 1'b0;
      f_instr_d = '0;
      f_bad_d   = 1'b0;
      d_rdy_d   = 1'b0;
      d_rdata_d = '0;
      bad_ld_d  = 1'b0;
      bad_st_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_f_req || bus.i_d_req) begin
               own_f_d = take_f;
               off_d   = req_addr - hit_base;
               wdata_d = take_f ? '0 : bus.i_d_wdata;
               we_d    = take_f ? 1'b0 : bus.i_d_we;
               size_d  = take_f ? 2'd2 : bus.i_d_size;
               idx_d   = hit_idx;
               bad_d   = req_bad;
               rdata_d = '0;
               cnt_d   = REGION_WAIT[hit_idx*4 +: 4];
               fair_d  = take_f ? 1'b0 : (bus.i_f_req ? 1'b1 : fair_q);
               state_d = req_bad ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rdata_d = bus.i_r_rdata[idx_q*W +: W];
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            // Response flops are set on leaving RESP so rdy lands at N+2+WAIT (N+1 when bad).
            state_d = ST_IDLE;
            if (own_f_q) begin
               f_rdy_d   = 1'b1;
               f_instr_d = rdata_q[31:0];
               f_bad_d   = bad_q;
            end else begin
               d_rdy_d   = 1'b1;
               d_rdata_d = rdata_q;
               bad_ld_d  = bad_q && !we_q;
               bad_st_d  = bad_q && we_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         own_f_q   <= 1'b0;
         off_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         size_q    <= '0;
         idx_q     <= '0;
         bad_q     <= 1'b0;
         fair_q    <= 1'b0;
         f_rdy_q   <= 1'b0;
         f_instr_q <= '0;
         f_bad_q   <= 1'b0;
         d_rdy_q   <= 1'b0;
         d_rdata_q <= '0;
         bad_ld_q  <= 1'b0;
         bad_st_q  <= 1'b0;
      end else if (i_clk_en) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         own_f_q   <= own_f_d;
         off_q     <= off_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         we_q      <= we_d;
         size_q    <= size_d;
         idx_q     <= idx_d;
         bad_q     <= bad_d;
         fair_q    <= fair_d;
         f_rdy_q   <= f_rdy_d;
         f_instr_q <= f_instr_d;
         f_bad_q   <= f_bad_d;
         d_rdy_q   <= d_rdy_d;
         d_rdata_q <= d_rdata_d;
         bad_ld_q  <= bad_ld_d;
         bad_st_q  <= bad_st_d;
      end
   end

   assign busy              = (state_q == ST_BUSY);
   assign bus.o_r_sel       = busy ? (NUM_REGIONS'(1) << idx_q) : '0;
   assign bus.o_r_addr      = busy ? off_q : '0;
   assign bus.o_r_wdata     = busy ? wdata_q : '0;
   assign bus.o_r_size      = busy ? size_q : '0;
   assign bus.o_r_we        = busy && (cnt_q == 4'd0) && we_q;
   assign bus.o_f_rdy       = f_rdy_q;
   assign bus.o_f_instr     = f_instr_q;
   assign bus.o_f_bad       = f_bad_q;
   assign bus.o_d_rdy       = d_rdy_q;
   assign bus.o_d_rdata     = d_rdata_q;
   assign bus.o_d_bad_load  = bad_ld_q;
   assign bus.o_d_bad_store = bad_st_q;
endmodule

// File: tb/tb_mem_fabric_arb.sv
// Bench for mem_fabric_arb: transaction-level timestamp model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_fabric_arb;
   localparam int unsigned W  = 64;
   localparam int unsigned NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clk_en = 1'b1;
   always #5 clk = ~clk;

   mem_fabric_arb_if #(.W(W), .NR(NR)) bus ();

   mem_fabric_arb #(.XLEN(2'b10), .NUM_REGIONS(NR)) dut (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .bus(bus)
   );

   logic [63:0] m_base  [NR] = '{64'h0, 64'h1000, 64'h2000, 64'h4000};
   logic [63:0] m_end   [NR] = '{64'h0FFF, 64'h1FFF, 64'h3FFF, 64'h40FF};
   int unsigned m_wait  [NR] = '{0, 1, 0, 3};
   bit          m_ro    [NR] = '{1'b1, 1'b1, 1'b0, 1'b0};
   bit          m_x     [NR] = '{1'b1, 1'b0, 1'b0, 1'b0};
   logic [63:0] rd_slice[NR] = '{64'h12345678_00500093, 64'hAAAABBBB_CCCCDDDD,
                                 64'h01234567_89ABCDEF, 64'hDEADBEEF_CAFEF00D};

   assign bus.i_r_rdata = {rd_slice[3], rd_slice[2], rd_slice[1], rd_slice[0]};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int m_decode(input logic [63:0] a);
      for (int i = 0; i < int'(NR); i++)
         if (a >= m_base[i] && a <= m_end[i]) return i;
      return -1;
   endfunction

   // Transaction model: one outstanding access, described by its grant edge and derived times.
   int unsigned e = 0;
   bit          m_act = 1'b0, m_f = 1'b0, m_we = 1'b0, m_bad = 1'b0, m_fair = 1'b0;
   int unsigned m_g = 0, m_w = 0, m_rdy_e = 0;
   int          m_idx = 0;
   logic [63:0] m_off = '0, m_wd = '0, m_data = '0;
   logic [1:0]  m_size = '0;
   bit          t_pick_f;
   logic [63:0] t_a;
   int          t_r;

   always @(posedge clk) begin
      if (rst) begin
         m_act  = 1'b0;
         m_fair = 1'b0;
      end else if (clk_en) begin
         e++;
         if (m_act && !m_bad && e == m_g + m_w + 1) m_data = rd_slice[m_idx];
         if ((!m_act || e > m_rdy_e) && (bus.i_f_req || bus.i_d_req)) begin
            t_pick_f = bus.i_f_req && (!bus.i_d_req || m_fair);
            t_a      = t_pick_f ? bus.i_f_addr : bus.i_d_addr;
            t_r      = m_decode(t_a);
            m_fair   = t_pick_f ? 1'b0 : (bus.i_f_req ? 1'b1 : m_fair);
            if (t_r < 0)
               m_bad = 1'b1;
            else if (t_pick_f)
               m_bad = !m_x[t_r] || (t_a % 4 != 0);
            else
               m_bad = (t_a % (64'd1 << bus.i_d_size) != 0) || (bus.i_d_we && m_ro[t_r]);
            m_idx   = (t_r < 0) ? 0 : t_r;
            m_w     = (t_r < 0) ? 0 : m_wait[t_r];
            m_off   = (t_r < 0) ? 64'd0 : t_a - m_base[t_r];
            m_f     = t_pick_f;
            m_we    = t_pick_f ? 1'b0 : bus.i_d_we;
            m_size  = t_pick_f ? 2'd2 : bus.i_d_size;
            m_wd    = t_pick_f ? 64'd0 : bus.i_d_wdata;
            m_data  = '0;
            m_g     = e;
            m_rdy_e = m_bad ? e + 1 : e + m_w + 2;
            m_act   = 1'b1;
         end
      end
   end

   bit x_busy, x_rdy;
   always @(negedge clk) begin
      x_busy = m_act && !m_bad && e <= m_g + m_w;
      x_rdy  = m_act && e == m_rdy_e;
      check("f_rdy",      bus.o_f_rdy,       x_rdy && m_f);
      check("f_instr",    bus.o_f_instr,     (x_rdy && m_f) ? m_data[31:0] : 64'd0);
      check("f_bad",      bus.o_f_bad,       x_rdy && m_f && m_bad);
      check("d_rdy",      bus.o_d_rdy,       x_rdy && !m_f);
      check("d_rdata",    bus.o_d_rdata,     (x_rdy && !m_f) ? m_data : 64'd0);
      check("d_bad_load", bus.o_d_bad_load,  x_rdy && !m_f && m_bad && !m_we);
      check("d_bad_st",   bus.o_d_bad_store, x_rdy && !m_f && m_bad && m_we);
      check("r_sel",      bus.o_r_sel,       x_busy ? (64'd1 << m_idx) : 64'd0);
      check("r_addr",     bus.o_r_addr,      x_busy ? m_off : 64'd0);
      check("r_we",       bus.o_r_we,        x_busy && m_we && e == m_g + m_w);
      check("r_wdata",    bus.o_r_wdata,     x_busy ? m_wd : 64'd0);
      check("r_size",     bus.o_r_size,      x_busy ? m_size : 64'd0);
   end

   int          lat, busy_n, we_n;
   logic [63:0] seen_sel, seen_addr;

   // Issue one request at a negedge and hold it until its rdy is seen.
   task automatic txn(input bit is_f, input bit we, input logic [63:0] a, input logic [63:0] wd,
                      input logic [1:0] sz);
      if (is_f) begin
         bus.i_f_req = 1'b1; bus.i_f_addr = a;
      end else begin
         bus.i_d_req = 1'b1; bus.i_d_we = we; bus.i_d_addr = a; bus.i_d_wdata = wd; bus.i_d_size = sz;
      end
      lat = 0; busy_n = 0; we_n = 0; seen_sel = '0; seen_addr = '0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); @(negedge clk);
         lat++;
         if (bus.o_r_sel != '0) begin
            busy_n++; seen_sel = 64'(bus.o_r_sel); seen_addr = bus.o_r_addr;
         end
         if (bus.o_r_we) we_n++;
         if (is_f ? bus.o_f_rdy : bus.o_d_rdy) begin
            bus.i_f_req = 1'b0; bus.i_d_req = 1'b0;
            return;
         end
      end
      check("txn_timeout", 64'd1, 64'd0);
      bus.i_f_req = 1'b0; bus.i_d_req = 1'b0;
   endtask

   int ev_who[4], ev_t[4], nev, rdy_n, we_en, stray;
   bit done;
   logic [63:0] we_addr, we_wd;

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_f_req = 1'b0; bus.i_f_addr = '0;
      bus.i_d_req = 1'b0; bus.i_d_we = 1'b0; bus.i_d_addr = '0; bus.i_d_wdata = '0; bus.i_d_size = '0;
      repeat (3) @(negedge clk);
      check("rst_f_rdy", bus.o_f_rdy, 64'd0);
      check("rst_d_rdy", bus.o_d_rdy, 64'd0);
      check("rst_r_sel", bus.o_r_sel, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      txn(1'b1, 1'b0, 64'h10, 64'd0, 2'd2);
      check("fetch0_lat",   lat - 1, 64'd2);
      check("fetch0_instr", bus.o_f_instr, 64'h00500093);
      check("fetch0_bad",   bus.o_f_bad, 64'd0);

      txn(1'b0, 1'b0, 64'h4008, 64'd0, 2'd3);
      check("io_lat",    lat - 1, 64'd5);
      check("io_rdata",  bus.o_d_rdata, 64'hDEADBEEF_CAFEF00D);
      check("io_busy_n", busy_n, 64'd4);
      check("io_sel",    seen_sel, 64'b1000);
      check("io_addr",   seen_addr, 64'h8);

      txn(1'b0, 1'b1, 64'h1004, 64'h55, 2'd2);
      check("ro_lat",   lat - 1, 64'd1);
      check("ro_bad",   bus.o_d_bad_store, 64'd1);
      check("ro_we_n",  we_n, 64'd0);
      check("ro_sel_n", busy_n, 64'd0);

      txn(1'b1, 1'b0, 64'h2000, 64'd0, 2'd2);
      check("nx_lat", lat - 1, 64'd1);
      check("nx_bad", bus.o_f_bad, 64'd1);

      txn(1'b0, 1'b0, 64'h2001, 64'd0, 2'd1);
      check("mis_bad_ld", bus.o_d_bad_load, 64'd1);
      check("mis_bad_st", bus.o_d_bad_store, 64'd0);

      txn(1'b0, 1'b0, 64'h5000, 64'd0, 2'd0);
      check("nohit_bad", bus.o_d_bad_load, 64'd1);

      txn(1'b0, 1'b0, 64'h1008, 64'd0, 2'd2);
      check("r1_lat",   lat - 1, 64'd3);
      check("r1_rdata", bus.o_d_rdata, 64'hAAAABBBB_CCCCDDDD);

      txn(1'b0, 1'b1, 64'h2010, 64'h77, 2'd3);
      check("st_lat",  lat - 1, 64'd2);
      check("st_we_n", we_n, 64'd1);

      // Both ports held: grants must alternate data, fetch, data.
      bus.i_f_req = 1'b1; bus.i_f_addr = 64'h10;
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 64'h2008; bus.i_d_size = 2'd3;
      nev = 0;
      for (int k = 0; k < 30 && nev < 3; k++) begin
         @(posedge clk); @(negedge clk);
         if (bus.o_d_rdy) begin ev_who[nev] = 0; ev_t[nev] = k; nev++; end
         if (bus.o_f_rdy && nev < 3) begin ev_who[nev] = 1; ev_t[nev] = k; nev++; end
      end
      bus.i_f_req = 1'b0; bus.i_d_req = 1'b0;
      check("alt_n", nev, 64'd3);
      if (nev == 3) begin
         check("alt_who0", ev_who[0], 64'd0);
         check("alt_who1", ev_who[1], 64'd1);
         check("alt_who2", ev_who[2], 64'd0);
         check("alt_gap1", ev_t[1] - ev_t[0], 64'd3);
         check("alt_gap2", ev_t[2] - ev_t[1], 64'd3);
      end
      @(negedge clk);

      // Byte store with the step enable toggling every cycle.
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_addr = 64'h3000; bus.i_d_wdata = 64'h11;
      bus.i_d_size = 2'd0;
      rdy_n = 0; we_en = 0; done = 1'b0; we_addr = '0; we_wd = '0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk); @(negedge clk);
         clk_en = ~clk_en;
         if (bus.o_r_we && clk_en) begin
            we_en++; we_addr = bus.o_r_addr; we_wd = bus.o_r_wdata;
         end
         if (bus.o_d_rdy) begin
            rdy_n++; bus.i_d_req = 1'b0;
         end else if (rdy_n > 0) begin
            done = 1'b1;
         end
      end
      clk_en = 1'b1;
      check("ce_done",  done, 64'd1);
      check("ce_rdy_n", rdy_n, 64'd2);
      check("ce_we_en", we_en, 64'd1);
      check("ce_addr",  we_addr, 64'h1000);
      check("ce_wdata", we_wd, 64'h11);
      @(negedge clk);

      // Reset while an IO load is waiting.
      bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 64'h4008; bus.i_d_size = 2'd3;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("mid_sel", bus.o_r_sel, 64'b1000);
      rst = 1'b1; bus.i_d_req = 1'b0;
      @(posedge clk); @(negedge clk);
      check("ar_sel",   bus.o_r_sel, 64'd0);
      check("ar_addr",  bus.o_r_addr, 64'd0);
      check("ar_we",    bus.o_r_we, 64'd0);
      check("ar_rdy",   bus.o_d_rdy, 64'd0);
      check("ar_rdata", bus.o_d_rdata, 64'd0);
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); @(negedge clk);
         if (bus.o_d_rdy || bus.o_r_we || bus.o_r_sel != '0) stray++;
      end
      check("ar_stray", stray, 64'd0);

      txn(1'b1, 1'b0, 64'h10, 64'd0, 2'd2);
      check("post_lat",   lat - 1, 64'd2);
      check("post_instr", bus.o_f_instr, 64'h00500093);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
